// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer: walks a 16-bit register list and moves one word per
// listed register between the register file and a ready-handshake data-memory port.
module ldm_stm_seq #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_load,
    input  logic          up,
    input  logic          pre,
    input  logic          wback,
    input  logic [15:0]   reg_list,
    input  logic [3:0]    base_reg,
    input  logic [AW-1:0] base_addr,
    output logic [3:0]    rf_ra,
    input  logic [DW-1:0] rf_rd,
    output logic          rf_we,
    output logic [3:0]    rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          pc_we,
    output logic [DW-1:0] pc_wd,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, WB, DONE} state_t;

    state_t        state;
    logic          is_load_q, up_q, pre_q, wback_q;
    logic [15:0]   list_q;
    logic [15:0]   pend;
    logic [3:0]    base_reg_q;
    logic [AW-1:0] base_q, cur_addr, final_addr;

    logic [3:0]    cur;
    logic [15:0]   pend_next;
    logic [4:0]    cnt;
    logic [AW-1:0] span, start_addr, end_addr;
    logic          do_wb;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++)
            c = c + 5'(v[i]);
        return c;
    endfunction

    // pend holds the registers still to transfer; cur is always its lowest set bit.
    always_comb begin
        cur        = lowest_set(pend);
        pend_next  = pend & ~(16'd1 << cur);
        cnt        = popcount(list_q);
        span       = AW'(cnt) << 2;
        end_addr   = up_q ? base_q + span : base_q - span;
        case ({up_q, pre_q})
            2'b10:   start_addr = base_q;
            2'b11:   start_addr = base_q + AW'(4);
            2'b00:   start_addr = end_addr + AW'(4);
            default: start_addr = end_addr;
        endcase
        do_wb = wback_q && !(is_load_q && list_q[base_reg_q]);
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_load_q  <= 1'b0;
            up_q       <= 1'b0;
            pre_q      <= 1'b0;
            wback_q    <= 1'b0;
            list_q     <= '0;
            pend       <= '0;
            base_reg_q <= '0;
            base_q     <= '0;
            cur_addr   <= '0;
            final_addr <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    is_load_q  <= is_load;
                    up_q       <= up;
                    pre_q      <= pre;
                    wback_q    <= wback;
                    list_q     <= reg_list;
                    base_reg_q <= base_reg;
                    base_q     <= base_addr & ~AW'(3);
                    state      <= SETUP;
                end
                SETUP: begin
                    pend       <= list_q;
                    cur_addr   <= start_addr;
                    final_addr <= end_addr;
                    state      <= (cnt == 5'd0) ? DONE : XFER;
                end
                XFER: if (mem_ready) begin
                    pend     <= pend_next;
                    cur_addr <= cur_addr + AW'(4);
                    if (pend_next == 16'd0)
                        state <= do_wb ? WB : DONE;
                end
                WB:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write strobes follow the handshake in the same cycle, so they decode mem_ready directly.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        rf_ra     = '0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            XFER: begin
                mem_req  = 1'b1;
                mem_we   = !is_load_q;
                mem_addr = cur_addr;
                rf_ra    = cur;
                if (!is_load_q)
                    mem_wdata = rf_rd;
                if (mem_ready && is_load_q) begin
                    if (cur == 4'd15) begin
                        pc_we = 1'b1;
                        pc_wd = mem_rdata & ~DW'(3);
                    end else begin
                        rf_we = 1'b1;
                        rf_wa = cur;
                        rf_wd = mem_rdata;
                    end
                end
            end
            WB: begin
                if (base_reg_q == 4'd15) begin
                    pc_we = 1'b1;
                    pc_wd = DW'(final_addr);
                end else begin
                    rf_we = 1'b1;
                    rf_wa = base_reg_q;
                    rf_wd = DW'(final_addr);
                end
            end
            default: ;
        endcase
    end

endmodule
